// File: rtl/seg_scan.sv
// seg_scan: multiplexed 7-segment scan driver, dead-time gaps between digits, loads applied only at frame boundaries.
// All outputs registered, no backpressure; define SEG_LZ_BLANK_EN to blank leading-zero digits.
module seg_scan #(
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int DIGITS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  dp_n,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int GW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic [0:0] S_GAP  = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  logic [0:0]          state;
  logic [PW-1:0]       pre_cnt;
  logic [GW-1:0]       gap_cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] display;
  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   dp_display;
  logic [DIGITS-1:0]   dp_shadow;

  logic                show_end;
  logic                gap_end;
  logic                enter_show;
  logic                boundary;
  logic [IW-1:0]       idx_next;
  logic [4*DIGITS-1:0] disp_eff;
  logic [DIGITS-1:0]   dp_eff;
  logic [3:0]          nib_next;
  logic                dp_next;
  logic                lit_next;

  always_comb begin
    show_end   = (state == S_SHOW) && (pre_cnt == PRE_LAST);
    gap_end    = (state == S_GAP) && ((DEAD_CYCLES == 0) || (gap_cnt == GAP_LAST));
    enter_show = gap_end || (show_end && (DEAD_CYCLES == 0));
    idx_next   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    boundary   = enter_show && (idx_next == '0);
    // The frame being entered shows the pending value from its very first digit.
    disp_eff   = (boundary && pending) ? shadow : display;
    dp_eff     = (boundary && pending) ? dp_shadow : dp_display;
    nib_next   = disp_eff[4*idx_next +: 4];
    dp_next    = dp_eff[idx_next];
`ifdef SEG_LZ_BLANK_EN
    lit_next   = (idx_next == '0) || ((disp_eff >> (4*idx_next)) != '0);
`else
    lit_next   = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_GAP;
      pre_cnt    <= '0;
      gap_cnt    <= '0;
      idx        <= IDX_LAST;
      display    <= '0;
      shadow     <= '0;
      dp_display <= '0;
      dp_shadow  <= '0;
      nibble     <= '0;
      an         <= '1;
      dp_n       <= 1'b1;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (boundary && pending) begin
        display    <= shadow;
        dp_display <= dp_shadow;
      end
      if (load) begin
        shadow    <= value;
        dp_shadow <= dp;
      end
      // A load on the boundary edge re-arms pending for the next frame.
      pending <= load | (pending & ~boundary);

      if (enter_show) begin
        state   <= S_SHOW;
        pre_cnt <= '0;
        idx     <= idx_next;
        nibble  <= nib_next;
        dp_n    <= ~(dp_next & lit_next);
        an      <= lit_next ? ~(DIGITS'(1) << idx_next) : '1;
      end else if (show_end) begin
        state   <= S_GAP;
        gap_cnt <= '0;
        an      <= '1;
      end else if (state == S_SHOW) begin
        pre_cnt <= pre_cnt + PW'(1);
      end else begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

endmodule
